host_cmd_rx: RTL
================

# host_cmd_rx

Command receiver for the host link: the host-to-FPGA direction of the LVDS communications interface, complementing the FIFO readout interface that drives data back to the host. It oversamples the host `sck`/`mosi` pair in the system `clk` domain and deframes 24-bit command words. It decodes them into register writes that control the AGC DAC word and the ADC control word and enables. It replaces the fixed power-up sequencer in the top level.

## Interface
- `IDLE_CYCLES`, default 1024: number of `clk` cycles without an `sck` rising edge that aborts a partial frame.
- `clk` in 1: system clock (PLL `GLA`); all logic on its rising edge.
- `arstn` in 1: reset, synchronous, active-low.
- `sck_in` in 1: host serial clock, asynchronous to `clk`.
- `mosi_in` in 1: host serial data, asynchronous to `clk`.
- `agc_data` out 16: AGC DAC word.
- `agc_load` out 1: one-cycle pulse that loads the AGC SPI writer.
- `adc_ctrlword` out 10: ADC control word, shared by the I and Q channels.
- `adc_ldctrl` out 1: one-cycle pulse that loads the ADC control word.
- `adc_enable` out 1: ADC acquisition enable, level output.
- `cmd_valid` out 1: one-cycle pulse when any complete frame is accepted.
- `cmd_addr` out 8: address field of the last accepted frame.
- `cmd_data` out 16: data field of the last accepted frame.
- `frame_err` out 1: one-cycle pulse on a timeout abort or an unknown address.
- `err_cnt` out 8: count of errors, saturating at 255.

## Operation
- **Input synchronisation:** `sck_in` and `mosi_in` each pass through 2 flip-flops, giving `s2`. A third flip-flop on `sck` gives `s3`.
  - Rising edge: `rise = sck_s2 & ~sck_s3`.
  - On `rise`, the bit sampled is `mosi_s2`.
- **Frame format:** 24 bits, MSB first.
  - Bits [23:16] are the address; bits [15:0] are the data.
  - There is no chip select. Framing is by bit count plus idle timeout.
- **State machine:**
  - IDLE: `bitcnt == 0`. On `rise`, shift in the bit, set `bitcnt = 1`, go to SHIFT.
  - SHIFT: on `rise`, shift in the bit and increment `bitcnt`.
    - On the 24th bit, go to DONE.
    - If `IDLE_CYCLES` consecutive cycles pass without `rise`: pulse `frame_err`, clear the shift register and `bitcnt`, go to IDLE.
  - DONE (1 cycle): latch `cmd_addr`/`cmd_data`, pulse `cmd_valid`, decode, go to IDLE.
    - A `rise` arriving during DONE is treated as bit 1 of the next frame; no bit is lost.
- **Address decode** (in DONE):
  - 0x00: NOP; no register changes.
  - 0x01: `agc_data <= data`; `agc_load` pulses the next cycle.
  - 0x02: `adc_ctrlword <= data[9:0]`; `adc_ldctrl` pulses the next cycle.
  - 0x03: `adc_enable <= data[0]`.
  - Any other address: no register change; `frame_err` pulses.
- **Error counter:** `err_cnt` increments on each `frame_err` pulse and holds at 255.
- **Reset values** while `arstn` is low at a `clk` edge:
  - `agc_data` = 16'h2AAA (1 V RMS).
  - `adc_ctrlword` = 10'b1010101010.
  - `adc_enable` = 0.
  - All pulse outputs = 0.
  - `cmd_addr` = 0, `cmd_data` = 0, `err_cnt` = 0.
  - Synchroniser flip-flops and the shift register cleared; FSM in IDLE; timeout counter cleared.
- **Reset mid-frame:** the partial frame is discarded with no `frame_err` pulse.

## Timing
- Host `sck` high and low times must each be at least 3 `clk` periods; faster `sck` is out of contract.
- Edge detection latency: `rise` asserts 2–3 `clk` cycles after the `sck_in` rising edge.
- Frame latency: `cmd_valid` asserts 1 cycle after the `rise` of bit 24.
  - `agc_data`, `adc_ctrlword` and `adc_enable` update in the same cycle as `cmd_valid`.
  - `agc_load`/`adc_ldctrl` assert 1 cycle after `cmd_valid`, so the new data is stable when loaded.
- The timeout counter resets on every `rise` and runs only in SHIFT.
  - The abort fires in the cycle the counter reaches `IDLE_CYCLES`.
- `frame_err` from timeout and from an unknown address cannot coincide (they occur in different states). `err_cnt` increments by at most 1 per cycle.

## Test plan
- **AGC write:** after reset, send frame 0x01_1234 → `agc_data` = 0x1234, `cmd_valid` one pulse, `agc_load` one pulse one cycle later, `err_cnt` = 0.
- **ADC control and enable:** send 0x02_03FF then 0x03_0001 → `adc_ctrlword` = 10'h3FF with one `adc_ldctrl` pulse, then `adc_enable` = 1. Send 0x03_0000 → `adc_enable` = 0.
- **Timeout abort:** send 10 bits, then hold `sck` low for `IDLE_CYCLES` cycles → `frame_err` one pulse, `err_cnt` = 1. Then send 0x01_00FF → `agc_data` = 0x00FF, confirming the frame resynchronised.
- **Unknown address and saturation:** send 0x7F_FFFF → `frame_err` pulses and no register changes. Send 300 such frames → `err_cnt` holds at 255.
- **Back-to-back frames:** send 0x01_AAAA immediately followed by 0x02_0155 at minimum `sck` period → both decoded, two `cmd_valid` pulses, `agc_data` = 0xAAAA, `adc_ctrlword` = 10'h155.
- **Reset mid-frame:** send 12 bits, assert `arstn` low for 1 cycle, then send 0x00_0000 → all outputs at reset values, no `frame_err`, and the NOP frame is accepted with `cmd_valid`.

Source files
------------

// File: rtl/host_cmd_rx.sv
// Host link command receiver: oversamples sck/mosi in the clk domain,
// deframes 24-bit words and turns them into AGC/ADC register writes.
module host_cmd_rx #(
   parameter int IDLE_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        arstn,
   input  logic        sck_in,
   input  logic        mosi_in,
   output logic [15:0] agc_data,
   output logic        agc_load,
   output logic [9:0]  adc_ctrlword,
   output logic        adc_ldctrl,
   output logic        adc_enable,
   output logic        cmd_valid,
   output logic [7:0]  cmd_addr,
   output logic [15:0] cmd_data,
   output logic        frame_err,
   output logic [7:0]  err_cnt
);

   localparam int TW = $clog2(IDLE_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   logic          sck_s1_q;
   logic          sck_s2_q;
   logic          sck_s3_q;
   logic          mosi_s1_q;
   logic          mosi_s2_q;
   logic          rise;

   state_t        state_q;
   state_t        state_d;
   logic [23:0]   shreg_q;
   logic [23:0]   shreg_d;
   logic [23:0]   shifted;
   logic [4:0]    bitcnt_q;
   logic [4:0]    bitcnt_d;
   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_d;

   logic [15:0]   agc_data_q;
   logic [15:0]   agc_data_d;
   logic [9:0]    adc_ctrl_q;
   logic [9:0]    adc_ctrl_d;
   logic          adc_en_q;
   logic          adc_en_d;
   logic [7:0]    cmd_addr_q;
   logic [7:0]    cmd_addr_d;
   logic [15:0]   cmd_data_q;
   logic [15:0]   cmd_data_d;
   logic          cmd_valid_q;
   logic          cmd_valid_d;
   logic          frame_err_q;
   logic          frame_err_d;
   logic [7:0]    err_cnt_q;
   logic [7:0]    err_cnt_d;
   logic          agc_pend_q;
   logic          agc_pend_d;
   logic          adc_pend_q;
   logic          adc_pend_d;
   logic          agc_load_q;
   logic          adc_ld_q;

   assign rise    = sck_s2_q & ~sck_s3_q;
   assign shifted = {shreg_q[22:0], mosi_s2_q};

   always_ff @(posedge clk) begin
      if (!arstn) begin
         sck_s1_q  <= 1'b0;
         sck_s2_q  <= 1'b0;
         sck_s3_q  <= 1'b0;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         sck_s1_q  <= sck_in;
         sck_s2_q  <= sck_s1_q;
         sck_s3_q  <= sck_s2_q;
         mosi_s1_q <= mosi_in;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      tmo_d       = '0;
      agc_data_d  = agc_data_q;
      adc_ctrl_d  = adc_ctrl_q;
      adc_en_d    = adc_en_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;
      cmd_valid_d = 1'b0;
      frame_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      agc_pend_d  = 1'b0;
      adc_pend_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (rise) begin
               shreg_d  = shifted;
               bitcnt_d = 5'd1;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (rise) begin
               shreg_d  = shifted;
               bitcnt_d = bitcnt_q + 5'd1;
               if (bitcnt_q == 5'd23) begin
                  state_d = S_DONE;
               end
            end else if (tmo_q == TMO_LAST) begin
               frame_err_d = 1'b1;
               shreg_d     = '0;
               bitcnt_d    = '0;
               state_d     = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_DONE: begin
            cmd_addr_d  = shreg_q[23:16];
            cmd_data_d  = shreg_q[15:0];
            cmd_valid_d = 1'b1;
            case (shreg_q[23:16])
               8'h00: ;
               8'h01: begin
                  agc_data_d = shreg_q[15:0];
                  agc_pend_d = 1'b1;
               end
               8'h02: begin
                  adc_ctrl_d = shreg_q[9:0];
                  adc_pend_d = 1'b1;
               end
               8'h03: adc_en_d = shreg_q[0];
               default: frame_err_d = 1'b1;
            endcase
            // a rise here already belongs to the next frame
            if (rise) begin
               shreg_d  = {23'd0, mosi_s2_q};
               bitcnt_d = 5'd1;
               state_d  = S_SHIFT;
            end else begin
               shreg_d  = '0;
               bitcnt_d = '0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (frame_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!arstn) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         tmo_q       <= '0;
         agc_data_q  <= 16'h2AAA;
         adc_ctrl_q  <= 10'b1010101010;
         adc_en_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
         agc_pend_q  <= 1'b0;
         adc_pend_q  <= 1'b0;
         agc_load_q  <= 1'b0;
         adc_ld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         tmo_q       <= tmo_d;
         agc_data_q  <= agc_data_d;
         adc_ctrl_q  <= adc_ctrl_d;
         adc_en_q    <= adc_en_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_data_q  <= cmd_data_d;
         cmd_valid_q <= cmd_valid_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
         agc_pend_q  <= agc_pend_d;
         adc_pend_q  <= adc_pend_d;
         agc_load_q  <= agc_pend_q;
         adc_ld_q    <= adc_pend_q;
      end
   end

   assign agc_data     = agc_data_q;
   assign agc_load     = agc_load_q;
   assign adc_ctrlword = adc_ctrl_q;
   assign adc_ldctrl   = adc_ld_q;
   assign adc_enable   = adc_en_q;
   assign cmd_valid    = cmd_valid_q;
   assign cmd_addr     = cmd_addr_q;
   assign cmd_data     = cmd_data_q;
   assign frame_err    = frame_err_q;
   assign err_cnt      = err_cnt_q;

endmodule
